// File: rtl/serial_cmp_ctrl.sv
// MSB-first serial magnitude-compare sequencer: latches A/B, steps one bit per clock, drives (y,z).
// Define SCMP_EARLY_EXIT_EN to stop at the first differing bit; otherwise all WIDTH bits are stepped.
module serial_cmp_ctrl #(
  parameter int WIDTH = 3,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             y,
  output logic             z,
  output logic [IDXW-1:0]  bit_idx
);

`ifdef SCMP_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [1:0] CODE_IDLE = 2'b00;
  localparam logic [1:0] CODE_EQ   = 2'b01;
  localparam logic [1:0] CODE_GT   = 2'b10;
  localparam logic [1:0] CODE_LT   = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [1:0]       code_q, code_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  logic             a_bit, b_bit, finish;
  logic [1:0]       bit_code;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;

    a_bit  = a_q[idx_q];
    b_bit  = b_q[idx_q];
    finish = 1'b0;

    // Once a difference has been seen (non-early-exit build), the code is frozen.
    if (code_q != CODE_EQ)   bit_code = code_q;
    else if (a_bit & ~b_bit) bit_code = CODE_GT;
    else if (~a_bit & b_bit) bit_code = CODE_LT;
    else                     bit_code = CODE_EQ;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDXW'(WIDTH - 1);
          code_d  = CODE_EQ;
          busy_d  = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        code_d = bit_code;
        finish = (idx_q == '0) || (EarlyExit && (bit_code != CODE_EQ));
        if (finish) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          gt_d    = (bit_code == CODE_GT);
          lt_d    = (bit_code == CODE_LT);
          eq_d    = (bit_code == CODE_EQ);
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      code_q  <= CODE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_gt_b  = gt_q;
  assign a_lt_b  = lt_q;
  assign a_eq_b  = eq_q;
  assign y       = code_q[1];
  assign z       = code_q[0];
  assign bit_idx = idx_q;

endmodule
